// File: rtl/proc_scheduler_pkg.sv
// rtl/proc_scheduler_pkg.sv - shared state encoding, widths and helpers for proc_scheduler
package proc_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  localparam int DEFAULT_NUM_UNITS = 4;
  localparam int POS_W             = 16;
  localparam int CHAR_W            = 8;

  // Index width that stays at least one bit wide for a single-unit bank.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/proc_scheduler_lsb_priority_enc.sv
// rtl/proc_scheduler_lsb_priority_enc.sv - lowest-set-bit index encoder with any flag
module lsb_priority_enc
  import proc_scheduler_pkg::*;
#(
  parameter int N     = DEFAULT_NUM_UNITS,
  parameter int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan from the top so the lowest set bit is the last one to write idx.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

  assign any = |vec;

endmodule

// File: rtl/proc_scheduler.sv
// rtl/proc_scheduler.sv - broadcasts jobs to a bank of md5 units and aggregates their results
module proc_scheduler
  import proc_scheduler_pkg::*;
#(
  parameter int NUM_UNITS = DEFAULT_NUM_UNITS,
  parameter int TIMEOUT_W = 24
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        s_start,
  input  logic [POS_W-1:0]            s_num_bytes,
  input  logic [CHAR_W-1:0]           s_data,
  input  logic                        s_data_valid,
  input  logic                        s_match_char_next,
  input  logic [NUM_UNITS-1:0]        unit_en,
  output logic                        s_done,
  output logic                        s_match,
  output logic [POS_W-1:0]            s_byte_pos,
  output logic [CHAR_W-1:0]           s_match_char,
  output logic                        busy,
  output logic                        timeout,
  output logic                        u_start,
  output logic [POS_W-1:0]            u_num_bytes,
  output logic [CHAR_W-1:0]           u_data,
  output logic                        u_data_valid,
  input  logic [NUM_UNITS-1:0]        u_done,
  input  logic [NUM_UNITS-1:0]        u_match,
  input  logic [POS_W*NUM_UNITS-1:0]  u_byte_pos,
  input  logic [CHAR_W*NUM_UNITS-1:0] u_match_char,
  output logic [NUM_UNITS-1:0]        u_match_char_next
);

  localparam int IDX_W = idx_width(NUM_UNITS);

  state_t               state;
  logic [NUM_UNITS-1:0] active;
  logic [NUM_UNITS-1:0] done_seen;
  logic [NUM_UNITS-1:0] match_seen;
  logic [TIMEOUT_W-1:0] wdog;
  logic [IDX_W-1:0]     sel;
  logic                 sel_valid;
  logic [IDX_W-1:0]     enc_idx;
  logic                 enc_any;
  logic [POS_W-1:0]     enc_pos;
  logic [NUM_UNITS-1:0] done_now;
  logic [NUM_UNITS-1:0] match_now;

  assign done_now  = u_done & active;
  assign match_now = u_done & u_match & active;

  lsb_priority_enc #(.N(NUM_UNITS), .IDX_W(IDX_W)) sel_enc (
    .vec (match_seen),
    .idx (enc_idx),
    .any (enc_any)
  );

  always_comb begin
    enc_pos = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (enc_idx == IDX_W'(i)) enc_pos = u_byte_pos[POS_W*i +: POS_W];
    end
  end

  // Readback is steered only after a report that found a winner.
  always_comb begin
    s_match_char      = '0;
    u_match_char_next = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (sel_valid && sel == IDX_W'(i)) begin
        s_match_char         = u_match_char[CHAR_W*i +: CHAR_W];
        u_match_char_next[i] = s_match_char_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      active       <= '0;
      done_seen    <= '0;
      match_seen   <= '0;
      wdog         <= '0;
      sel          <= '0;
      sel_valid    <= 1'b0;
      s_done       <= 1'b0;
      s_match      <= 1'b0;
      s_byte_pos   <= '0;
      busy         <= 1'b0;
      timeout      <= 1'b0;
      u_start      <= 1'b0;
      u_num_bytes  <= '0;
      u_data       <= '0;
      u_data_valid <= 1'b0;
    end else begin
      u_start      <= s_start;
      u_num_bytes  <= s_num_bytes;
      u_data       <= s_data;
      u_data_valid <= s_data_valid;
      s_done       <= 1'b0;

      if (s_start) begin
        active     <= unit_en;
        done_seen  <= '0;
        match_seen <= '0;
        wdog       <= '0;
        timeout    <= 1'b0;
        s_match    <= 1'b0;
        s_byte_pos <= '0;
        sel        <= '0;
        sel_valid  <= 1'b0;
        busy       <= 1'b1;
        state      <= (unit_en == '0) ? ST_REPORT : ST_RUN;
      end else begin
        unique case (state)
          ST_RUN: begin
            done_seen  <= done_seen | done_now;
            match_seen <= match_seen | match_now;
            wdog       <= wdog + 1'b1;
            // Completion on the watchdog's final cycle still counts as a clean finish.
            if ((done_seen | done_now) == active) begin
              state <= ST_REPORT;
            end else if ((wdog + 1'b1) == {TIMEOUT_W{1'b1}}) begin
              timeout    <= 1'b1;
              match_seen <= '0;
              state      <= ST_REPORT;
            end
          end
          ST_REPORT: begin
            s_done     <= 1'b1;
            s_match    <= enc_any;
            sel        <= enc_idx;
            sel_valid  <= enc_any;
            s_byte_pos <= enc_any ? enc_pos : '0;
            busy       <= 1'b0;
            state      <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_proc_scheduler.sv
// tb/tb_proc_scheduler.sv - randomized self-checking bench for proc_scheduler
module tb_proc_scheduler;

  localparam int NU       = 4;
  localparam int TW       = 4;
  localparam int WD_LIMIT = (1 << TW) - 1;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            s_start = 1'b0;
  logic [15:0]     s_num_bytes = '0;
  logic [7:0]      s_data = '0;
  logic            s_data_valid = 1'b0;
  logic            s_match_char_next = 1'b0;
  logic [NU-1:0]   unit_en = '0;
  logic            s_done, s_match, busy, timeout, u_start, u_data_valid;
  logic [15:0]     s_byte_pos, u_num_bytes;
  logic [7:0]      s_match_char, u_data;
  logic [NU-1:0]   u_done = '0;
  logic [NU-1:0]   u_match = '0;
  logic [16*NU-1:0] u_byte_pos = '0;
  logic [8*NU-1:0] u_match_char;
  logic [NU-1:0]   u_match_char_next;

  proc_scheduler #(.NUM_UNITS(NU), .TIMEOUT_W(TW)) dut (
    .clk(clk), .reset_n(reset_n), .s_start(s_start), .s_num_bytes(s_num_bytes),
    .s_data(s_data), .s_data_valid(s_data_valid), .s_match_char_next(s_match_char_next),
    .unit_en(unit_en), .s_done(s_done), .s_match(s_match), .s_byte_pos(s_byte_pos),
    .s_match_char(s_match_char), .busy(busy), .timeout(timeout), .u_start(u_start),
    .u_num_bytes(u_num_bytes), .u_data(u_data), .u_data_valid(u_data_valid),
    .u_done(u_done), .u_match(u_match), .u_byte_pos(u_byte_pos),
    .u_match_char(u_match_char), .u_match_char_next(u_match_char_next)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_pulses = 0;
  int last_done_cyc = 0;
  int rb1_pulses = 0;
  int char_cnt[NU] = '{0, 0, 0, 0};

  // Each fake unit presents a character stream that steps on its own advance pulse.
  always_comb begin
    u_match_char = '0;
    for (int i = 0; i < NU; i++) u_match_char[8*i +: 8] = 8'(16 * i + char_cnt[i]);
  end

  // Job-level reference: which enabled units are still outstanding, who matched, how long it ran.
  int            m_mode = 0;
  logic [NU-1:0] m_active = '0, m_seen = '0, m_matched = '0;
  int            m_runcnt = 0;
  int            m_sel = 0;
  logic          m_sel_valid = 1'b0, m_done = 1'b0, m_match = 1'b0, m_busy = 1'b0, m_timeout = 1'b0;
  logic [15:0]   m_bp = '0, m_unb = '0;
  logic          m_ustart = 1'b0, m_udv = 1'b0;
  logic [7:0]    m_ud = '0;

  always @(posedge clk) begin
    cyc++;
    if (s_match_char_next && m_sel_valid) char_cnt[m_sel]++;
    if (!reset_n) begin
      m_mode = 0; m_active = '0; m_seen = '0; m_matched = '0; m_runcnt = 0;
      m_sel = 0; m_sel_valid = 0; m_done = 0; m_match = 0; m_busy = 0; m_timeout = 0;
      m_bp = '0; m_unb = '0; m_ustart = 0; m_udv = 0; m_ud = '0;
    end else begin
      m_ustart = s_start; m_unb = s_num_bytes; m_ud = s_data; m_udv = s_data_valid;
      m_done = 0;
      if (s_start) begin
        m_active = unit_en; m_seen = '0; m_matched = '0; m_runcnt = 0; m_timeout = 0;
        m_match = 0; m_bp = '0; m_sel = 0; m_sel_valid = 0;
        m_mode = (unit_en == '0) ? 2 : 1;
      end else if (m_mode == 1) begin
        m_seen    = m_seen | (u_done & m_active);
        m_matched = m_matched | (u_done & u_match & m_active);
        m_runcnt++;
        if (m_seen == m_active) m_mode = 2;
        else if (m_runcnt >= WD_LIMIT) begin
          m_timeout = 1; m_matched = '0; m_mode = 2;
        end
      end else if (m_mode == 2) begin
        m_done = 1; m_match = (m_matched != '0); m_sel_valid = m_match; m_sel = 0; m_bp = '0;
        for (int i = 0; i < NU; i++) if (m_matched[i]) begin m_sel = i; break; end
        if (m_match) m_bp = u_byte_pos[16*m_sel +: 16];
        m_mode = 0;
      end
      m_busy = (m_mode != 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    logic [7:0]    exp_char;
    logic [NU-1:0] exp_next;
    if (s_done === 1'b1) begin done_pulses++; last_done_cyc = cyc; end
    if (u_match_char_next[1] === 1'b1) rb1_pulses++;
    exp_char = m_sel_valid ? 8'(16 * m_sel + char_cnt[m_sel]) : 8'h00;
    exp_next = (s_match_char_next && m_sel_valid) ? NU'(1 << m_sel) : '0;
    chk("s_done", s_done, m_done);
    chk("s_match", s_match, m_match);
    chk("s_byte_pos", s_byte_pos, m_bp);
    chk("busy", busy, m_busy);
    chk("timeout", timeout, m_timeout);
    chk("u_start", u_start, m_ustart);
    chk("u_num_bytes", u_num_bytes, m_unb);
    chk("u_data", u_data, m_ud);
    chk("u_data_valid", u_data_valid, m_udv);
    chk("s_match_char", s_match_char, exp_char);
    chk("u_match_char_next", u_match_char_next, exp_next);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_bus();
    s_data            = 8'($urandom);
    s_data_valid      = 1'($urandom_range(0, 1));
    s_num_bytes       = 16'($urandom);
    s_match_char_next = 1'($urandom_range(0, 1));
  endtask

  // Done offsets are in drive steps after the start step; -1 means the unit never finishes.
  task automatic run_job(input logic [3:0] en, input int d0, input int d1, input int d2, input int d3,
                         input logic [3:0] mm, input logic [15:0] p0, input logic [15:0] p1,
                         input logic [15:0] p2, input logic [15:0] p3, input int abort_at,
                         output int c0);
    int  da[4] = '{d0, d1, d2, d3};
    bit  fin = 0;
    u_byte_pos = {p3, p2, p1, p0};
    s_start = 1; unit_en = en; rand_bus();
    u_done = 4'($urandom); u_match = 4'($urandom);
    c0 = cyc;
    step();
    s_start = 0; unit_en = 4'($urandom);
    for (int k = 1; k <= 40; k++) begin
      if (k == abort_at) begin u_done = '0; u_match = '0; return; end
      u_done = '0;
      for (int i = 0; i < NU; i++) if (da[i] == k) u_done[i] = 1'b1;
      u_match = (mm & u_done) | (4'($urandom) & ~u_done);
      rand_bus();
      step();
      if (m_mode == 0) begin fin = 1; break; end
    end
    if (!fin) begin
      n_cmp++; n_fail++;
      $display("FAIL job_bound: job still running after 40 cycles, required finished");
    end
    u_done = 4'($urandom); u_match = 4'($urandom); s_match_char_next = 0;
    step();
    u_done = '0; u_match = '0;
    step();
  endtask

  initial begin
    int c0, pulses0;
    repeat (3) step();
    chk("reset_s_done", s_done, 0);
    chk("reset_u_start", u_start, 0);
    chk("reset_busy", busy, 0);
    reset_n = 1;
    step();

    run_job(4'hF, 5, 7, 6, 10, 4'h0, 16'h11, 16'h22, 16'h33, 16'h44, -1, c0);
    chk("s1_latency", last_done_cyc - c0, 12);
    chk("s1_match", s_match, 0);
    chk("s1_pos", s_byte_pos, 0);
    chk("s1_busy", busy, 0);

    run_job(4'hF, 3, 4, 5, 6, 4'b1010, 16'h0aaa, 16'h0123, 16'h0bbb, 16'h0456, -1, c0);
    chk("s2_match", s_match, 1);
    chk("s2_pos", s_byte_pos, 16'h0123);
    rb1_pulses = 0;
    for (int n = 0; n < 20; n++) begin s_match_char_next = 1; step(); end
    s_match_char_next = 0;
    step();
    chk("s2_readback_pulses", rb1_pulses, 20);

    run_job(4'b0101, 3, -1, 5, 4, 4'b1000, 16'h1, 16'h2, 16'h3, 16'h4, -1, c0);
    chk("s3_latency", last_done_cyc - c0, 7);
    chk("s3_match", s_match, 0);

    run_job(4'hF, 2, 3, -1, 4, 4'b0100, 16'h5, 16'h6, 16'h7, 16'h8, -1, c0);
    chk("to_latency", last_done_cyc - c0, 17);
    chk("to_flag", timeout, 1);
    chk("to_match", s_match, 0);

    pulses0 = done_pulses;
    run_job(4'hF, 2, 3, 20, 20, 4'h0, 16'h0, 16'h0, 16'h0, 16'h0, 6, c0);
    run_job(4'hF, 11, 12, 3, 4, 4'b0001, 16'h0777, 16'h0, 16'h0, 16'h0, -1, c0);
    chk("rs_timeout_cleared", timeout, 0);
    chk("rs_done_count", done_pulses - pulses0, 1);
    chk("rs_latency", last_done_cyc - c0, 14);
    chk("rs_pos", s_byte_pos, 16'h0777);

    run_job(4'hF, 9, 9, 9, 9, 4'hF, 16'h1, 16'h2, 16'h3, 16'h4, 4, c0);
    reset_n = 0;
    step();
    chk("rst_busy", busy, 0);
    chk("rst_u_start", u_start, 0);
    chk("rst_u_data_valid", u_data_valid, 0);
    chk("rst_s_match_char", s_match_char, 0);
    reset_n = 1;
    step();

    for (int n = 0; n < 300; n++) begin
      rand_bus();
      step();
    end

    for (int j = 0; j < 25; j++) begin
      int d[4];
      int ab;
      for (int i = 0; i < NU; i++) d[i] = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(1, 12));
      ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(2, 8)) : -1;
      run_job(4'($urandom), d[0], d[1], d[2], d[3], 4'($urandom),
              16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), ab, c0);
      for (int n = 0; n < 3; n++) begin
        s_match_char_next = 1'($urandom_range(0, 1));
        step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
